hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
Pipeline hazard and sequencing controller for the 5-stage LEGv8 datapath. It sits beside the execute-stage forwarding logic and covers the hazards forwarding cannot resolve:
- load-use stalls (one bubble into ID/EX);
- taken-branch flushes (branch resolved in MEM);
- whole-pipeline freezes while data memory is busy, holding a branch redirect that arrives during a freeze until the pipeline resumes.

It also keeps saturating event counters for performance debug.

Parameters:
CW, 32, width of each event counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous active-low reset
IF_IDRegRn  in  5  Rn field of instruction in IF/ID
IF_IDRegRm  in  5  Rm/Rt source field of instruction in IF/ID
IF_IDreadsRn  in  1  instruction in IF/ID reads Rn
IF_IDreadsRm  in  1  instruction in IF/ID reads Rm/Rt
ID_EXmemRead  in  1  instruction in ID/EX is a load
ID_EXRegRd  in  5  destination of instruction in ID/EX
PCSrc_M  in  1  branch taken, resolved in MEM
mem_busy  in  1  data memory not ready; pipeline must hold
PCWrite  out  1  PC register enable
IF_IDWrite  out  1  IF/ID enable
PipeWrite  out  1  enable for ID/EX, EX/MEM, MEM/WB
ID_EXbubble  out  1  zero control fields written into ID/EX
IF_IDflush  out  1  clear IF/ID
ID_EXflush  out  1  clear ID/EX
EX_MEMflush  out  1  clear EX/MEM
PCSrc_out  out  1  select branch target at PC mux
stall_cnt  out  CW  load-use bubble cycles
flush_cnt  out  CW  branch flush events
freeze_cnt  out  CW  frozen cycles

Behaviour:
- reset low (async): state=RUN, br_pend=0, all counters 0.
- While reset is low: all write enables 0, all flushes 0, ID_EXbubble 0, PCSrc_out 0.
- State is registered; hazard outputs are combinational from inputs and registered state, so they act in the same cycle.
- FSM states:
  - RUN: RUN->FREEZE when mem_busy=1.
  - FREEZE: FREEZE->RUN when mem_busy=0.
- br_pend:
  - set on any edge where mem_busy=1 and PCSrc_M=1;
  - cleared on the edge at which a flush is issued.
- Signal definitions:
  - redirect = (PCSrc_M | br_pend) & !mem_busy.
  - luh = ID_EXmemRead & (ID_EXRegRd != XZR) & ((IF_IDreadsRn & IF_IDRegRn==ID_EXRegRd) | (IF_IDreadsRm & IF_IDRegRm==ID_EXRegRd)).
  - Register 31 (XZR) never creates a hazard.
- Priority: mem_busy > redirect > luh > normal.
  - mem_busy=1: PCWrite=IF_IDWrite=PipeWrite=0; flushes=0; ID_EXbubble=0; PCSrc_out=0; freeze_cnt++.
  - redirect: PCWrite=IF_IDWrite=PipeWrite=1; IF_IDflush=ID_EXflush=EX_MEMflush=1; PCSrc_out=1; ID_EXbubble=0; flush_cnt++. A load-use hazard in the same cycle is discarded, because the younger instruction is flushed.
  - luh: PCWrite=0, IF_IDWrite=0, PipeWrite=1, ID_EXbubble=1; stall_cnt++. Next cycle ID/EX holds the bubble (memRead=0), so exactly one stall cycle results.
  - normal: all enables 1; flushes, bubble and PCSrc_out 0.
- The exit cycle of FREEZE (state=FREEZE, mem_busy=0) follows the normal priority, so a pending branch flushes in that cycle.
- Counters:
  - saturate at all-ones; no wrap;
  - increment at most once per cycle;
  - cleared only by reset.
- Reset asserted mid-freeze or with br_pend set: pending redirect is lost. The PC reset vector governs.

Decomposition:
- hazard_pkg:
  - state enum {RUN, FREEZE};
  - localparam XZR = 5'd31.
- Sub-module sat_counter (parameter W; ports clk, reset, inc, count) instantiated three times.
- Comparator and priority logic stay in hazard_control.

Test Plan:
1. Load-use: ID_EXmemRead=1, ID_EXRegRd=5, IF_IDRegRn=5, IF_IDreadsRn=1 -> PCWrite=0, IF_IDWrite=0, ID_EXbubble=1 for exactly 1 cycle; stall_cnt=1.
2. XZR / unused source:
   - ID_EXRegRd=31 matching IF_IDRegRm=31 -> no stall.
   - IF_IDreadsRm=0 with Rm match -> no stall.
3. Branch vs load-use: PCSrc_M=1 in the same cycle as luh -> all three flushes=1, PCSrc_out=1, PCWrite=1, ID_EXbubble=0; flush_cnt=1, stall_cnt=0.
4. Branch during freeze: mem_busy=1 for 3 cycles with PCSrc_M pulsed in cycle 1 -> all enables 0 and freeze_cnt=3; on the first cycle with mem_busy=0, flushes=1 and PCSrc_out=1 once; br_pend cleared.
5. Async reset mid-freeze: reset low between clock edges -> state=RUN, br_pend=0, counters 0 immediately; outputs all 0 while low.
6. Saturation: CW=4, 20 consecutive load-use events -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline-side bundle of hazard inputs, register controls and debug counters.
interface hazard_control_if #(
  parameter int CW = 32
);

  logic [4:0]    IF_IDRegRn;
  logic [4:0]    IF_IDRegRm;
  logic          IF_IDreadsRn;
  logic          IF_IDreadsRm;
  logic          ID_EXmemRead;
  logic [4:0]    ID_EXRegRd;
  logic          PCSrc_M;
  logic          mem_busy;

  logic          PCWrite;
  logic          IF_IDWrite;
  logic          PipeWrite;
  logic          ID_EXbubble;
  logic          IF_IDflush;
  logic          ID_EXflush;
  logic          EX_MEMflush;
  logic          PCSrc_out;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] freeze_cnt;

  // Datapath side: supplies hazard information, consumes enables and flushes.
  modport master (
    output IF_IDRegRn, IF_IDRegRm, IF_IDreadsRn, IF_IDreadsRm,
    output ID_EXmemRead, ID_EXRegRd, PCSrc_M, mem_busy,
    input  PCWrite, IF_IDWrite, PipeWrite, ID_EXbubble,
    input  IF_IDflush, ID_EXflush, EX_MEMflush, PCSrc_out,
    input  stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  IF_IDRegRn, IF_IDRegRm, IF_IDreadsRn, IF_IDreadsRm,
    input  ID_EXmemRead, ID_EXRegRd, PCSrc_M, mem_busy,
    output PCWrite, IF_IDWrite, PipeWrite, ID_EXbubble,
    output IF_IDflush, ID_EXflush, EX_MEMflush, PCSrc_out,
    output stall_cnt, flush_cnt, freeze_cnt
  );

endinterface

// File: rtl/hazard_control_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Load-use stall, branch flush and memory-freeze sequencing for the 5-stage pipeline.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int CW = 32
) (
  input logic            clk,
  input logic            reset,
  hazard_control_if.slave hz
);

  state_t state_reg, state_next;
  logic   br_pend_reg, br_pend_next;
  logic   redirect;
  logic   luh;
  logic   rn_match, rm_match;
  logic   pc_write, if_id_write, pipe_write, id_ex_bubble;
  logic   flush_all, pc_src;
  logic   stall_inc, flush_inc, freeze_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= RUN;
      br_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      br_pend_reg <= br_pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (hz.mem_busy)  state_next = FREEZE;
      FREEZE:  if (!hz.mem_busy) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign rn_match = hz.IF_IDreadsRn && (hz.IF_IDRegRn == hz.ID_EXRegRd);
  assign rm_match = hz.IF_IDreadsRm && (hz.IF_IDRegRm == hz.ID_EXRegRd);
  assign luh      = hz.ID_EXmemRead && (hz.ID_EXRegRd != XZR) && (rn_match || rm_match);
  assign redirect = (hz.PCSrc_M || br_pend_reg) && !hz.mem_busy;

  // A branch resolved while frozen is remembered until the flush actually happens.
  always_comb begin
    br_pend_next = br_pend_reg;
    if (hz.mem_busy && hz.PCSrc_M) begin
      br_pend_next = 1'b1;
    end else if (redirect) begin
      br_pend_next = 1'b0;
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    pipe_write   = 1'b0;
    id_ex_bubble = 1'b0;
    flush_all    = 1'b0;
    pc_src       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    freeze_inc   = 1'b0;
    if (!reset) begin
      pc_write = 1'b0;
    end else if (hz.mem_busy) begin
      freeze_inc = 1'b1;
    end else if (redirect) begin
      // The younger instruction is squashed, so any load-use hazard is moot.
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      pipe_write  = 1'b1;
      flush_all   = 1'b1;
      pc_src      = 1'b1;
      flush_inc   = 1'b1;
    end else if (luh) begin
      pipe_write   = 1'b1;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      pipe_write  = 1'b1;
    end
  end

  assign hz.PCWrite     = pc_write;
  assign hz.IF_IDWrite  = if_id_write;
  assign hz.PipeWrite   = pipe_write;
  assign hz.ID_EXbubble = id_ex_bubble;
  assign hz.IF_IDflush  = flush_all;
  assign hz.ID_EXflush  = flush_all;
  assign hz.EX_MEMflush = flush_all;
  assign hz.PCSrc_out   = pc_src;

  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (hz.stall_cnt)
  );

  sat_counter #(.W(CW)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (hz.flush_cnt)
  );

  sat_counter #(.W(CW)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze_inc),
    .count (hz.freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Random and directed checking of hazard_control against a rule-level reference model.
module tb_hazard_control;

  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_control_if #(.CW(CW)) hz ();

  hazard_control #(.CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: pending branch flag and three event tallies.
  bit m_pend;
  int m_stall, m_flush, m_freeze;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {hz.PCWrite, hz.IF_IDWrite, hz.PipeWrite, hz.ID_EXbubble,
            hz.IF_IDflush, hz.ID_EXflush, hz.EX_MEMflush, hz.PCSrc_out};
  endfunction

  function automatic int sat_add(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Called at posedge+1; returns at the next posedge+1 with the model advanced.
  task automatic apply(input logic [4:0] rn, input logic [4:0] rm, input bit rrn, input bit rrm,
                       input bit mr, input logic [4:0] rd, input bit br, input bit busy);
    bit hazard, redir;
    logic [7:0] exp;
    hz.IF_IDRegRn   = rn;
    hz.IF_IDRegRm   = rm;
    hz.IF_IDreadsRn = rrn;
    hz.IF_IDreadsRm = rrm;
    hz.ID_EXmemRead = mr;
    hz.ID_EXRegRd   = rd;
    hz.PCSrc_M      = br;
    hz.mem_busy     = busy;
    hazard = mr && (rd != 5'd31) && ((rrn && rn == rd) || (rrm && rm == rd));
    redir  = (br || m_pend) && !busy;
    if (busy)        exp = 8'b0000_0000;
    else if (redir)  exp = 8'b1110_1111;
    else if (hazard) exp = 8'b0011_0000;
    else             exp = 8'b1110_0000;
    @(negedge clk);
    check_eq("outs", {24'd0, outs()}, {24'd0, exp});
    check_eq("stall_cnt", 32'(hz.stall_cnt), 32'(m_stall));
    check_eq("flush_cnt", 32'(hz.flush_cnt), 32'(m_flush));
    check_eq("freeze_cnt", 32'(hz.freeze_cnt), 32'(m_freeze));
    $display("vec rn=%0d rm=%0d rd=%0d mr=%0b br=%0b busy=%0b outs=%b exp=%b", rn, rm, rd, mr, br, busy, outs(), exp);
    @(posedge clk);
    if (busy) begin
      m_freeze = sat_add(m_freeze);
      if (br) m_pend = 1'b1;
    end else if (redir) begin
      m_flush = sat_add(m_flush);
      m_pend  = 1'b0;
    end else if (hazard) begin
      m_stall = sat_add(m_stall);
    end
    #1;
  endtask

  task automatic idle();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must drop at once.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    check_eq("rst_outs", {24'd0, outs()}, 32'd0);
    check_eq("rst_cnts", {20'd0, hz.stall_cnt, hz.flush_cnt, hz.freeze_cnt}, 32'd0);
    m_pend = 1'b0; m_stall = 0; m_flush = 0; m_freeze = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    hz.IF_IDRegRn = '0; hz.IF_IDRegRm = '0; hz.IF_IDreadsRn = 1'b0; hz.IF_IDreadsRm = 1'b0;
    hz.ID_EXmemRead = 1'b0; hz.ID_EXRegRd = '0; hz.PCSrc_M = 1'b0; hz.mem_busy = 1'b0;
    m_pend = 1'b0; m_stall = 0; m_flush = 0; m_freeze = 0;
    #1;
    check_eq("init_outs", {24'd0, outs()}, 32'd0);
    check_eq("init_stall", 32'(hz.stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Load-use: one bubble, then ID/EX carries the bubble so the pipe resumes.
    apply(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    apply(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_eq("lu_stall1", 32'(hz.stall_cnt), 32'd1);

    // XZR destination and unused Rm never stall.
    apply(5'd0, 5'd31, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
    apply(5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    check_eq("xzr_stall", 32'(hz.stall_cnt), 32'd1);

    // Branch wins over a simultaneous load-use hazard.
    do_reset();
    apply(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    check_eq("br_flush", 32'(hz.flush_cnt), 32'd1);
    check_eq("br_stall", 32'(hz.stall_cnt), 32'd0);

    // Branch arriving mid-freeze is replayed on the first free cycle, once.
    do_reset();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    check_eq("frz_cnt3", 32'(hz.freeze_cnt), 32'd3);
    idle();
    idle();
    check_eq("frz_flush1", 32'(hz.flush_cnt), 32'd1);

    // Reset during a freeze with a pending branch: the branch is forgotten.
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    do_reset();
    hz.mem_busy = 1'b0; hz.PCSrc_M = 1'b0;
    idle();
    check_eq("rst_nopend", 32'(hz.flush_cnt), 32'd0);

    // Saturation: twenty back-to-back load-use events.
    do_reset();
    for (int i = 0; i < 20; i++) apply(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    check_eq("sat_stall", 32'(hz.stall_cnt), 32'(SAT));

    // Random traffic with small register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rn, rm, rd;
      logic [2:0] pick;
      if ((i % 60) == 59) do_reset();
      pick = 3'($urandom_range(0, 4)); rn = (pick == 3'd4) ? 5'd31 : 5'(pick);
      pick = 3'($urandom_range(0, 4)); rm = (pick == 3'd4) ? 5'd31 : 5'(pick);
      pick = 3'($urandom_range(0, 4)); rd = (pick == 3'd4) ? 5'd31 : 5'(pick);
      apply(rn, rm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 60), rd,
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 25));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
